// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking data-cache miss controller (write-back, burst refill); DCACHE_CTRL_STATS_EN adds hit/miss counters.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int SET_WIDTH  = 512,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_req_valid,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_hit,
  input  logic                  i_dirty,
  input  logic [ADDR_WIDTH-1:0] i_addr_wb,
  input  logic [SET_WIDTH-1:0]  i_data_block,
  output logic                  o_write_en,
  output logic                  o_block_we,
  output logic                  o_mem_access,
  output logic [SET_WIDTH-1:0]  o_data_block,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_arvalid,
  input  logic                  i_mem_arready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_mem_wvalid,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_wready,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
);
  localparam int BEATS = SET_WIDTH / DATA_WIDTH;
  localparam int BW = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(SET_WIDTH / 8 - 1);
  localparam logic [2:0] IDLE = 3'd0, WB = 3'd1, REFILL_REQ = 3'd2, REFILL = 3'd3, ALLOC = 3'd4;

  logic [2:0] state, state_nx;
  logic [BW-1:0] beat;
  logic last, hit_now, miss_start, beat_adv;

  assign last       = beat == BW'(BEATS - 1);
  assign hit_now    = state == IDLE && i_req_valid && i_hit;
  assign miss_start = state == IDLE && i_req_valid && !i_hit;
  assign beat_adv   = (state == WB && i_mem_wready) || (state == REFILL && i_mem_rvalid);

  assign o_mem_access  = hit_now;
  assign o_done        = hit_now;
  assign o_write_en    = hit_now && i_req_we;
  assign o_block_we    = state == ALLOC;
  assign o_mem_arvalid = state == REFILL_REQ;
  assign o_mem_wvalid  = state == WB;
  assign o_mem_wdata   = i_data_block[beat*DATA_WIDTH +: DATA_WIDTH];
  assign o_mem_addr    = state == WB ? i_addr_wb : i_addr & ~OFF_MASK;

  always_comb begin
    state_nx = miss_start                             ? (i_dirty ? WB : REFILL_REQ) :
               (state == WB && i_mem_wready && last)  ? REFILL_REQ :
               (state == REFILL_REQ && i_mem_arready) ? REFILL :
               (state == REFILL && i_mem_rvalid && last) ? ALLOC :
               state == ALLOC                         ? IDLE : state;
  end

  // beat wraps to 0 after the last write beat, so refill starts from beat 0
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state        <= IDLE;
      beat         <= '0;
      o_data_block <= '0;
    end else begin
      state <= state_nx;
      if (beat_adv) beat <= beat + 1'b1;
      if (state == REFILL && i_mem_rvalid) o_data_block[beat*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
    end
  end

`ifdef DCACHE_CTRL_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic miss_pend;
  // miss_pend marks a request that already missed so its final hit is not counted
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      hit_q     <= '0;
      miss_q    <= '0;
      miss_pend <= 1'b0;
    end else begin
      if (o_done && !miss_pend) hit_q <= hit_q + 1'b1;
      if (miss_start) miss_q <= miss_q + 1'b1;
      miss_pend <= miss_start ? 1'b1 : (state == IDLE && (o_done || !i_req_valid)) ? 1'b0 : miss_pend;
    end
  end
  assign o_hit_count  = hit_q;
  assign o_miss_count = miss_q;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl.
module tb_dcache_ctrl;
  logic         i_clk = 0, i_arstn = 0;
  logic         i_req_valid = 0, i_req_we = 0, i_hit = 0, i_dirty = 0;
  logic [63:0]  i_addr = '0, i_addr_wb = '0;
  logic [511:0] i_data_block = '0;
  logic         o_write_en, o_block_we, o_mem_access, o_done, o_mem_arvalid, o_mem_wvalid;
  logic [511:0] o_data_block;
  logic [63:0]  o_mem_addr, o_mem_wdata;
  logic         i_mem_arready = 0, i_mem_rvalid = 0, i_mem_wready = 0;
  logic [63:0]  i_mem_rdata = '0;
  logic [31:0]  o_hit_count, o_miss_count;
  int checks = 0, errors = 0;
  logic [511:0] exp_blk;

  dcache_ctrl dut (
    .i_clk(i_clk), .i_arstn(i_arstn), .i_req_valid(i_req_valid), .i_req_we(i_req_we),
    .i_addr(i_addr), .i_hit(i_hit), .i_dirty(i_dirty), .i_addr_wb(i_addr_wb),
    .i_data_block(i_data_block), .o_write_en(o_write_en), .o_block_we(o_block_we),
    .o_mem_access(o_mem_access), .o_data_block(o_data_block), .o_done(o_done),
    .o_mem_addr(o_mem_addr), .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_mem_wvalid(o_mem_wvalid),
    .o_mem_wdata(o_mem_wdata), .i_mem_wready(i_mem_wready),
    .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic one_hit();
    i_req_valid = 1; i_hit = 1; i_req_we = 0; #1;
    chk("hit_done", o_done, 1);
    chk("hit_access", o_mem_access, 1);
    chk("hit_we", o_write_en, 0);
    step();
    i_req_valid = 0; i_hit = 0;
  endtask

  initial begin
    #12;
    chk("rst_done", o_done, 0);
    chk("rst_blk", o_data_block, 0);
    chk("rst_hits", o_hit_count, 0);
    chk("rst_miss", o_miss_count, 0);
    i_arstn = 1;
    step();
    one_hit();
    // clean store miss
    i_addr = 64'h1234; i_req_we = 1; i_req_valid = 1; i_hit = 0; i_dirty = 0; #1;
    chk("miss_done", o_done, 0);
    chk("miss_idle_ar", o_mem_arvalid, 0);
    step();
    chk("ar_valid", o_mem_arvalid, 1);
    chk("ar_addr", o_mem_addr, 64'h1200);
    step();
    chk("ar_hold", o_mem_addr, 64'h1200);
    i_mem_arready = 1;
    step();
    i_mem_arready = 0;
    chk("refill_ar_low", o_mem_arvalid, 0);
    exp_blk = '0;
    for (int k = 0; k < 8; k++) begin
      i_mem_rvalid = 1; i_mem_rdata = 64'(k);
      exp_blk[k*64 +: 64] = 64'(k);
      step();
      chk("refill_no_bwe", o_block_we, k == 7);
    end
    i_mem_rvalid = 0;
    chk("alloc_blk", o_data_block, exp_blk);
    step();
    chk("alloc_one_cycle", o_block_we, 0);
    i_hit = 1; #1;
    chk("st_done", o_done, 1);
    chk("st_we", o_write_en, 1);
    step();
    i_req_valid = 0; i_hit = 0; i_req_we = 0;
    // dirty miss with write stall on beat 2
    for (int k = 0; k < 8; k++) i_data_block[k*64 +: 64] = 64'hA000 + 64'(k);
    i_addr = 64'h4040; i_addr_wb = 64'h8000; i_req_valid = 1; i_dirty = 1;
    step();
    i_dirty = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        i_mem_wready = 0;
        repeat (3) begin
          #1;
          chk("wb_stall_data", o_mem_wdata, 64'hA002);
          chk("wb_stall_addr", o_mem_addr, 64'h8000);
          step();
        end
      end
      i_mem_wready = 1; #1;
      chk("wb_valid", o_mem_wvalid, 1);
      chk("wb_addr", o_mem_addr, 64'h8000);
      chk("wb_data", o_mem_wdata, 64'hA000 + 64'(k));
      step();
    end
    i_mem_wready = 0;
    chk("wb_done_ar", o_mem_arvalid, 1);
    chk("wb_done_addr", o_mem_addr, 64'h4040);
    i_mem_arready = 1;
    step();
    i_mem_arready = 0;
    for (int k = 0; k < 8; k++) begin
      i_mem_rvalid = 1; i_mem_rdata = 64'h100 + 64'(k);
      exp_blk[k*64 +: 64] = 64'h100 + 64'(k);
      step();
    end
    i_mem_rvalid = 0;
    chk("dirty_bwe", o_block_we, 1);
    chk("dirty_blk", o_data_block, exp_blk);
    step();
    i_hit = 1; #1;
    chk("dirty_done", o_done, 1);
    step();
    i_req_valid = 0; i_hit = 0;
    one_hit();
    one_hit();
`ifdef DCACHE_CTRL_STATS_EN
    chk("hit_count", o_hit_count, 3);
    chk("miss_count", o_miss_count, 2);
`else
    chk("hit_count", o_hit_count, 0);
    chk("miss_count", o_miss_count, 0);
`endif
    // reset during refill beat 4
    i_addr = 64'h2000; i_req_valid = 1; i_hit = 0; i_dirty = 0;
    step();
    i_mem_arready = 1;
    step();
    i_mem_arready = 0;
    for (int k = 0; k < 4; k++) begin
      i_mem_rvalid = 1; i_mem_rdata = 64'hF0 + 64'(k);
      step();
    end
    i_arstn = 0; #1;
    chk("rst_mid_blk", o_data_block, 0);
    chk("rst_mid_hits", o_hit_count, 0);
    chk("rst_mid_miss", o_miss_count, 0);
    chk("rst_mid_bwe", o_block_we, 0);
    i_req_valid = 0;
    step();
    i_arstn = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_bwe", o_block_we, 0);
    end
    i_mem_rvalid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning byte address width.
REQ-002 SHALL have parameter SET_WIDTH, default 512, meaning cache block width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, meaning memory beat width; BEATS = SET_WIDTH/DATA_WIDTH (8).
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  clock; i_arstn  in  1  reset, active low.
REQ-005 SHALL have i_req_valid  in  1  CPU load/store request, held stable until o_done.
REQ-006 SHALL have i_req_we  in  1  request is a store.
REQ-007 SHALL have i_addr  in  ADDR_WIDTH  request address.
REQ-008 SHALL have i_hit, i_dirty  in  1 each  cache hit and victim-dirty flags.
REQ-009 SHALL have i_addr_wb  in  ADDR_WIDTH  victim write-back address.
REQ-010 SHALL have i_data_block  in  SET_WIDTH  victim block.
REQ-011 SHALL have o_write_en, o_block_we, o_mem_access  out  1 each  cache control.
REQ-012 SHALL have o_data_block  out  SET_WIDTH  assembled refill block.
REQ-013 SHALL have o_done  out  1  request completes this cycle.
REQ-014 SHALL have o_mem_addr  out  ADDR_WIDTH  memory address.
REQ-015 SHALL have o_mem_arvalid  out  1 and i_mem_arready  in  1  read-request handshake.
REQ-016 SHALL have i_mem_rvalid  in  1 and i_mem_rdata  in  DATA_WIDTH  read beats.
REQ-017 SHALL have o_mem_wvalid  out  1, o_mem_wdata  out  DATA_WIDTH, and i_mem_wready  in  1  write beats.
REQ-018 SHALL have o_hit_count, o_miss_count  out  32 each  statistics.

Function
REQ-019 SHALL implement states IDLE, WB, REFILL_REQ, REFILL, ALLOC.
REQ-020 In IDLE with i_req_valid & i_hit, SHALL assert o_mem_access=1, o_write_en=i_req_we, o_done=1 combinationally, and remain in IDLE (zero-latency hit).
REQ-021 In IDLE with i_req_valid & !i_hit, SHALL go to WB if i_dirty, else to REFILL_REQ; o_done=0.
REQ-022 In WB, SHALL drive o_mem_wvalid=1, o_mem_addr=i_addr_wb, o_mem_wdata=i_data_block[beat*DATA_WIDTH +: DATA_WIDTH] with beat 0 first; beat SHALL advance on wvalid&wready; after beat BEATS-1 is accepted, SHALL go to REFILL_REQ with the beat counter cleared.
REQ-023 In REFILL_REQ, SHALL drive o_mem_arvalid=1 and o_mem_addr=i_addr with its low log2(SET_WIDTH/8) bits zeroed; on i_mem_arready, SHALL go to REFILL.
REQ-024 In REFILL, each i_mem_rvalid beat SHALL be written to o_data_block[beat*DATA_WIDTH +: DATA_WIDTH]; after beat BEATS-1, SHALL go to ALLOC.
REQ-025 In ALLOC, SHALL assert o_block_we=1 for exactly one cycle, then go to IDLE, where the held request hits.
REQ-026 The beat counter SHALL be log2(BEATS) bits wide and SHALL wrap to 0 after BEATS-1.
REQ-027 If i_req_valid drops during a miss, SHALL complete the current fill without asserting o_done.
REQ-028 Outside the states named in REQ-020 to REQ-025, o_write_en, o_block_we, o_mem_access, o_mem_arvalid, o_mem_wvalid, and o_done SHALL be 0.
REQ-029 o_mem_wdata and o_mem_addr SHALL remain stable while valid is high and ready is low.

Reset
REQ-030 On i_arstn=0, state SHALL become IDLE, and the beat counter, o_data_block, and the counters SHALL become 0, asynchronously.
REQ-031 Reset mid-WB or mid-REFILL SHALL abandon the transfer; no o_block_we SHALL follow.

Configuration
REQ-032 With DCACHE_CTRL_STATS_EN defined, o_hit_count SHALL increment on each o_done cycle not preceded by a miss for that request, and o_miss_count SHALL increment on each IDLE to WB or IDLE to REFILL_REQ transition; both counters SHALL wrap.
REQ-033 Without DCACHE_CTRL_STATS_EN, both count ports SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-034 Load hit: i_req_valid=1, i_hit=1, i_req_we=0 -> o_done=1 and o_mem_access=1 in the same cycle, o_write_en=0.
REQ-035 Clean store miss at addr 0x1234: i_hit=0, i_dirty=0 -> arvalid with o_mem_addr=0x1200; 8 beats 0x0..0x7 -> o_block_we pulse with o_data_block beat k=k; next cycle i_hit=1 -> o_write_en=1 and o_done=1.
REQ-036 Dirty miss: i_addr_wb=0x8000 -> 8 write beats at 0x8000 in order; wready low for 3 cycles on beat 2 -> wdata held; then refill proceeds.
REQ-037 Reset asserted at REFILL beat 4 -> IDLE immediately, no o_block_we, counters 0.
REQ-038 With DCACHE_CTRL_STATS_EN defined: 3 hits and 2 misses -> o_hit_count=3, o_miss_count=2; without the macro -> both 0.
